// File: rtl/qr_grid_sampler_pkg.sv
// Shared types and constants for the QR grid sampler.
// QR_MAJORITY_VOTE_EN selects 3 samples per module instead of 1.
package qr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } sampler_state_t;

`ifdef QR_MAJORITY_VOTE_EN
    localparam int SAMPLES_PER_MODULE = 3;
`else
    localparam int SAMPLES_PER_MODULE = 1;
`endif

    localparam int COORD_W = 12;

    function automatic int code_size_of(input int version);
        return 17 + 4 * version;
    endfunction

endpackage

// File: rtl/qr_grid_sampler_if.sv
// Control, frame-buffer read and result signals of the grid sampler.
interface qr_grid_sampler_if #(
    parameter int CODE_SIZE = 21,
    parameter int ADDR_W    = 20
) ();
    logic                           start_in;
    logic [8:0]                     module_size;
    logic [8:0]                     center_x;
    logic [8:0]                     center_y;
    logic [ADDR_W-1:0]              read_addr;
    logic                           read_valid;
    logic                           pixel_in;
    logic [CODE_SIZE*CODE_SIZE-1:0] qr_code;
    logic                           busy;
    logic                           valid_qr;
    logic                           bounds_error;

    modport master (
        output start_in, module_size, center_x, center_y, pixel_in,
        input  read_addr, read_valid, qr_code, busy, valid_qr, bounds_error
    );

    modport slave (
        input  start_in, module_size, center_x, center_y, pixel_in,
        output read_addr, read_valid, qr_code, busy, valid_qr, bounds_error
    );
endinterface

// File: rtl/qr_grid_sampler_tag_pipe.sv
// Delay line carrying {valid, tag} alongside an in-flight BRAM read so the
// tag emerges in the same cycle as the read data.
module qr_read_tag_pipe #(
    parameter int DEPTH = 2,
    parameter int TAG_W = 8
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             in_valid,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    output logic [TAG_W-1:0] out_tag
);

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic             valid_d, valid_q;
            logic [TAG_W-1:0] tag_d, tag_q;

            if (gi == 0) begin : g_src
                always_comb begin
                    valid_d = in_valid;
                    tag_d   = in_tag;
                end
            end else begin : g_src
                always_comb begin
                    valid_d = g_stage[gi-1].valid_q;
                    tag_d   = g_stage[gi-1].tag_q;
                end
            end

            always_ff @(posedge clk_in) begin
                if (rst_in) begin
                    valid_q <= 1'b0;
                    tag_q   <= '0;
                end else begin
                    valid_q <= valid_d;
                    tag_q   <= tag_d;
                end
            end
        end
    endgenerate

    assign out_valid = g_stage[DEPTH-1].valid_q;
    assign out_tag   = g_stage[DEPTH-1].tag_q;

endmodule

// File: rtl/qr_grid_sampler.sv
// Samples a CODE_SIZE x CODE_SIZE module grid from a binarised frame buffer.
// QR_MAJORITY_VOTE_EN enables 2-of-3 voting over centre and centre+-q in x.
module qr_grid_sampler
    import qr_pkg::*;
#(
    parameter int CODE_SIZE    = code_size_of(1),
    parameter int WIDTH        = 480,
    parameter int HEIGHT       = 320,
    parameter int ADDR_W       = 20,
    parameter int READ_LATENCY = 2
) (
    input logic              clk_in,
    input logic              rst_in,
    qr_grid_sampler_if.slave bus
);

    localparam int N2    = CODE_SIZE * CODE_SIZE;
    localparam int IDX_W = $clog2(N2);
    localparam int XY_W  = $clog2(CODE_SIZE);
    localparam int TAG_W = IDX_W + 2;
    localparam logic [1:0]      S_LAST = 2'(SAMPLES_PER_MODULE - 1);
    localparam logic [XY_W-1:0] XY_LAST = XY_W'(CODE_SIZE - 1);

    sampler_state_t            state_q, state_d;
    logic [8:0]                ms_q, ms_d, cx_q, cx_d, cy_q, cy_d;
    logic                      busy_q, busy_d, valid_qr_q, valid_qr_d;
    logic                      bounds_error_q, bounds_error_d;
    logic                      read_valid_q, read_valid_d;
    logic [ADDR_W-1:0]         read_addr_q, read_addr_d;
    logic [N2-1:0]             qr_code_q, qr_code_d;
    logic [XY_W-1:0]           x_q, x_d, y_q, y_d;
    logic [1:0]                s_q, s_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic signed [COORD_W-1:0] colx_q, colx_d, rowy_q, rowy_d;
    logic [2:0]                drain_q, drain_d;
`ifdef QR_MAJORITY_VOTE_EN
    logic [1:0]                vote_q, vote_d;
`endif

    logic             tag_valid, sample_bit, out_of_frame;
    logic [TAG_W-1:0] tag_out;
    logic [IDX_W-1:0] tag_idx;
    logic [1:0]       tag_s;
    int               q_i, ms_i, min_x_i, min_y_i, max_x_i, max_y_i, margin_i;

    qr_read_tag_pipe #(.DEPTH(READ_LATENCY), .TAG_W(TAG_W)) u_tag_pipe (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .in_valid (read_valid_q),
        .in_tag   ({idx_q, s_q}),
        .out_valid(tag_valid),
        .out_tag  (tag_out)
    );

    assign tag_idx = tag_out[TAG_W-1:2];
    assign tag_s   = tag_out[1:0];

    function automatic logic [ADDR_W-1:0] addr_of(
        input logic signed [COORD_W-1:0] row,
        input logic signed [COORD_W-1:0] col,
        input logic [1:0]                s,
        input logic [8:0]                ms
    );
        int q, px, a;
        q  = int'(ms >> 2);
        px = int'(col);
        if (s == 2'd1)      px = px - q;
        else if (s == 2'd2) px = px + q;
        a = int'(row) * WIDTH + px;
        return a[ADDR_W-1:0];
    endfunction

    // Bounds are evaluated at full integer width so oversized pitches cannot
    // wrap back into the frame; an accepted grid always fits COORD_W.
    always_comb begin
        ms_i     = int'(ms_q);
        q_i      = int'(ms_q >> 2);
        min_x_i  = int'(cx_q) - 3 * ms_i;
        min_y_i  = int'(cy_q) - 3 * ms_i;
        max_x_i  = min_x_i + (CODE_SIZE - 1) * ms_i;
        max_y_i  = min_y_i + (CODE_SIZE - 1) * ms_i;
        margin_i = (SAMPLES_PER_MODULE == 3) ? q_i : 0;
        out_of_frame = (min_x_i - margin_i < 0) || (min_y_i < 0) ||
                       (max_x_i + margin_i >= WIDTH) || (max_y_i >= HEIGHT);
    end

    always_comb begin
        state_d        = state_q;
        ms_d           = ms_q;
        cx_d           = cx_q;
        cy_d           = cy_q;
        busy_d         = busy_q;
        valid_qr_d     = 1'b0;
        bounds_error_d = 1'b0;
        read_valid_d   = read_valid_q;
        read_addr_d    = read_addr_q;
        qr_code_d      = qr_code_q;
        x_d            = x_q;
        y_d            = y_q;
        s_d            = s_q;
        idx_d          = idx_q;
        colx_d         = colx_q;
        rowy_d         = rowy_q;
        drain_d        = drain_q;
`ifdef QR_MAJORITY_VOTE_EN
        vote_d = vote_q;
        if (tag_valid && tag_s == 2'd0) vote_d[0] = bus.pixel_in;
        if (tag_valid && tag_s == 2'd1) vote_d[1] = bus.pixel_in;
        sample_bit = (vote_q[0] & vote_q[1]) | (vote_q[0] & bus.pixel_in) |
                     (vote_q[1] & bus.pixel_in);
`else
        sample_bit = bus.pixel_in;
`endif
        if (tag_valid && tag_s == S_LAST) qr_code_d[tag_idx] = sample_bit;

        case (state_q)
            ST_IDLE: begin
                if (bus.start_in) begin
                    ms_d      = bus.module_size;
                    cx_d      = bus.center_x;
                    cy_d      = bus.center_y;
                    qr_code_d = '0;
                    busy_d    = 1'b1;
                    state_d   = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (out_of_frame) begin
                    bounds_error_d = 1'b1;
                    busy_d         = 1'b0;
                    state_d        = ST_IDLE;
                end else begin
                    read_valid_d = 1'b1;
                    x_d          = '0;
                    y_d          = '0;
                    s_d          = '0;
                    idx_d        = '0;
                    colx_d       = COORD_W'(min_x_i);
                    rowy_d       = COORD_W'(min_y_i);
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (x_q == XY_LAST && y_q == XY_LAST && s_q == S_LAST) begin
                    read_valid_d = 1'b0;
                    drain_d      = '0;
                    state_d      = ST_DRAIN;
                end else if (s_q != S_LAST) begin
                    s_d = s_q + 2'd1;
                end else begin
                    s_d   = '0;
                    idx_d = idx_q + 1'b1;
                    if (x_q == XY_LAST) begin
                        x_d    = '0;
                        y_d    = y_q + 1'b1;
                        colx_d = COORD_W'(min_x_i);
                        rowy_d = rowy_q + COORD_W'(ms_q);
                    end else begin
                        x_d    = x_q + 1'b1;
                        colx_d = colx_q + COORD_W'(ms_q);
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_q == 3'(READ_LATENCY - 1)) begin
                    valid_qr_d = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = ST_DONE;
                end else begin
                    drain_d = drain_q + 3'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_ISSUE) read_addr_d = addr_of(rowy_d, colx_d, s_d, ms_q);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q        <= ST_IDLE;
            ms_q           <= '0;
            cx_q           <= '0;
            cy_q           <= '0;
            busy_q         <= 1'b0;
            valid_qr_q     <= 1'b0;
            bounds_error_q <= 1'b0;
            read_valid_q   <= 1'b0;
            read_addr_q    <= '0;
            qr_code_q      <= '0;
            x_q            <= '0;
            y_q            <= '0;
            s_q            <= '0;
            idx_q          <= '0;
            colx_q         <= '0;
            rowy_q         <= '0;
            drain_q        <= '0;
`ifdef QR_MAJORITY_VOTE_EN
            vote_q         <= '0;
`endif
        end else begin
            state_q        <= state_d;
            ms_q           <= ms_d;
            cx_q           <= cx_d;
            cy_q           <= cy_d;
            busy_q         <= busy_d;
            valid_qr_q     <= valid_qr_d;
            bounds_error_q <= bounds_error_d;
            read_valid_q   <= read_valid_d;
            read_addr_q    <= read_addr_d;
            qr_code_q      <= qr_code_d;
            x_q            <= x_d;
            y_q            <= y_d;
            s_q            <= s_d;
            idx_q          <= idx_d;
            colx_q         <= colx_d;
            rowy_q         <= rowy_d;
            drain_q        <= drain_d;
`ifdef QR_MAJORITY_VOTE_EN
            vote_q         <= vote_d;
`endif
        end
    end

    assign bus.read_addr    = read_addr_q;
    assign bus.read_valid   = read_valid_q;
    assign bus.qr_code      = qr_code_q;
    assign bus.busy         = busy_q;
    assign bus.valid_qr     = valid_qr_q;
    assign bus.bounds_error = bounds_error_q;

endmodule
